// File: rtl/avalon_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one Avalon-MM master path; one transfer per grant.
// Optional watchdog that forces completion of a stuck transfer: define ARB_TIMEOUT_EN.
module avalon_rr_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      iClk,
    input  logic                      iRst,
    // requester 0
    input  logic                      avalonRead0,
    input  logic                      avalonWrite0,
    input  logic [ADDR_WIDTH-1:0]     avalonAddr0,
    input  logic [DATA_WIDTH/8-1:0]   avalonBE0,
    input  logic [DATA_WIDTH-1:0]     avalonWriteData0,
    output logic                      avalonWaitReq0,
    output logic                      avalonReadValid0,
    output logic [DATA_WIDTH-1:0]     avalonReadData0,
    // requester 1
    input  logic                      avalonRead1,
    input  logic                      avalonWrite1,
    input  logic [ADDR_WIDTH-1:0]     avalonAddr1,
    input  logic [DATA_WIDTH/8-1:0]   avalonBE1,
    input  logic [DATA_WIDTH-1:0]     avalonWriteData1,
    output logic                      avalonWaitReq1,
    output logic                      avalonReadValid1,
    output logic [DATA_WIDTH-1:0]     avalonReadData1,
    // downstream master path
    output logic                      avmRead,
    output logic                      avmWrite,
    output logic [ADDR_WIDTH-1:0]     avmAddr,
    output logic [DATA_WIDTH/8-1:0]   avmBE,
    output logic [DATA_WIDTH-1:0]     avmWriteData,
    input  logic                      avmWaitReq,
    input  logic                      avmReadValid,
    input  logic [DATA_WIDTH-1:0]     avmReadData,
    // status
    output logic                      oGrant,
    output logic                      oBusy,
    output logic                      oTimeoutErr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_RDATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;

    logic                  req0_c, req1_c;
    logic                  wr_g_c, rd_g_c;
    logic                  busy_c;
    logic                  done_c, rvalid_c, timeout_c, at_limit_c;
    logic                  cpl0_c, cpl1_c;
    logic [DATA_WIDTH-1:0] rdata_c;

    // A write strobe takes priority over a simultaneous read strobe
    assign req0_c = avalonRead0 | avalonWrite0;
    assign req1_c = avalonRead1 | avalonWrite1;
    assign wr_g_c = grant_q ? avalonWrite1 : avalonWrite0;
    assign rd_g_c = (grant_q ? avalonRead1 : avalonRead0) & ~wr_g_c;
    assign busy_c = (state_q != S_IDLE);

    // Downstream command mux follows the registered grant
    assign avmAddr      = grant_q ? avalonAddr1      : avalonAddr0;
    assign avmBE        = grant_q ? avalonBE1        : avalonBE0;
    assign avmWriteData = grant_q ? avalonWriteData1 : avalonWriteData0;
    assign avmWrite     = (state_q == S_XFER) & wr_g_c;
    assign avmRead      = (state_q == S_XFER) & rd_g_c;

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Arbitration, transfer sequencing and completion decode
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_c    = 1'b0;
        rvalid_c  = 1'b0;
        timeout_c = 1'b0;
        rdata_c   = avmReadData;

        unique case (state_q)
            S_IDLE: begin
                if (req0_c && req1_c) begin
                    grant_d = ~grant_q;
                    state_d = S_XFER;
                end else if (req0_c) begin
                    grant_d = 1'b0;
                    state_d = S_XFER;
                end else if (req1_c) begin
                    grant_d = 1'b1;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (wr_g_c) begin
                    if (!avmWaitReq) begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (rd_g_c) begin
                    if (!avmWaitReq) begin
                        if (avmReadValid) begin
                            done_c   = 1'b1;
                            rvalid_c = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d = S_RDATA;
                        end
                    end
                end else begin
                    // Requester withdrew before acceptance: nothing to complete
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (avmReadValid) begin
                    done_c   = 1'b1;
                    rvalid_c = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A genuine completion in the limit cycle wins over the watchdog
        timeout_c = at_limit_c & ~done_c;
        if (timeout_c) begin
            done_c   = 1'b1;
            rvalid_c = (state_q == S_RDATA) | rd_g_c;
            rdata_c  = DATA_WIDTH'(32'hDEADBEEF);
            state_d  = S_IDLE;
        end
    end

    // Completion is routed only to the granted port
    assign cpl0_c = busy_c & ~grant_q & done_c;
    assign cpl1_c = busy_c &  grant_q & done_c;

    assign avalonWaitReq0   = req0_c & ~cpl0_c;
    assign avalonWaitReq1   = req1_c & ~cpl1_c;
    assign avalonReadValid0 = cpl0_c & rvalid_c;
    assign avalonReadValid1 = cpl1_c & rvalid_c;
    assign avalonReadData0  = grant_q ? '0 : rdata_c;
    assign avalonReadData1  = grant_q ? rdata_c : '0;

    assign oGrant = grant_q;
    assign oBusy  = busy_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter sits at zero in IDLE, so every XFER entry starts from a clean count
    always_comb begin
        cnt_d      = busy_c ? (cnt_q + CNT_W'(1)) : '0;
        err_d      = err_q | timeout_c;
        at_limit_c = busy_c & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign oTimeoutErr = err_q;
`else
    // Without the watchdog the limit has no effect
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign at_limit_c         = 1'b0;
    assign oTimeoutErr        = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Scoreboard bench for avalon_rr_arbiter: directed transfers, downstream command and
// per-port completion monitors. Define ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_avalon_rr_arbiter;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned BW     = DW / 8;
    localparam int unsigned TMO    = 16;
    localparam int          BUDGET = 64;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        bit            is_rd;
        logic [DW-1:0] data;
    } cpl_t;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]    rd, wr, waitreq, rvalid;
    logic [AW-1:0] addr  [2];
    logic [BW-1:0] be    [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] rdata [2];

    logic          avmRead, avmWrite, avmWaitReq, avmReadValid;
    logic [AW-1:0] avmAddr;
    logic [BW-1:0] avmBE;
    logic [DW-1:0] avmWriteData, avmReadData;
    logic          oGrant, oBusy, oTimeoutErr;

    int   checks   = 0;
    int   failures = 0;
    cmd_t exp_cmd  [$];
    cpl_t exp_cpl0 [$];
    cpl_t exp_cpl1 [$];

    bit            slave_mute = 1'b0;
    int            pend = 0;
    logic [DW-1:0] pend_data;

    always #5 clk = ~clk;

    avalon_rr_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .iClk             (clk),
        .iRst             (rst),
        .avalonRead0      (rd[0]),
        .avalonWrite0     (wr[0]),
        .avalonAddr0      (addr[0]),
        .avalonBE0        (be[0]),
        .avalonWriteData0 (wdata[0]),
        .avalonWaitReq0   (waitreq[0]),
        .avalonReadValid0 (rvalid[0]),
        .avalonReadData0  (rdata[0]),
        .avalonRead1      (rd[1]),
        .avalonWrite1     (wr[1]),
        .avalonAddr1      (addr[1]),
        .avalonBE1        (be[1]),
        .avalonWriteData1 (wdata[1]),
        .avalonWaitReq1   (waitreq[1]),
        .avalonReadValid1 (rvalid[1]),
        .avalonReadData1  (rdata[1]),
        .avmRead          (avmRead),
        .avmWrite         (avmWrite),
        .avmAddr          (avmAddr),
        .avmBE            (avmBE),
        .avmWriteData     (avmWriteData),
        .avmWaitReq       (avmWaitReq),
        .avmReadValid     (avmReadValid),
        .avmReadData      (avmReadData),
        .oGrant           (oGrant),
        .oBusy            (oBusy),
        .oTimeoutErr      (oTimeoutErr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic push_cmd(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic [DW-1:0] d);
        cmd_t c;
        c.wr = w; c.addr = a; c.be = b; c.wdata = d;
        exp_cmd.push_back(c);
    endtask

    task automatic push_cpl(input int p, input bit r, input logic [DW-1:0] d);
        cpl_t e;
        e.is_rd = r; e.data = d;
        if (p == 0) exp_cpl0.push_back(e);
        else        exp_cpl1.push_back(e);
    endtask

    // Present one request and hold it until the port's waitrequest drops
    task automatic drive(input int p, input bit w, input bit r, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [DW-1:0] d);
        int n;
        @(posedge clk); #1;
        wr[p] = w; rd[p] = r; addr[p] = a; be[p] = b; wdata[p] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (waitreq[p] && n < BUDGET);
        if (waitreq[p]) flag($sformatf("port%0d_completion_timeout", p), 64'(waitreq[p]), 64'd0);
    endtask

    task automatic release_port(input int p);
        @(posedge clk); #1;
        rd[p] = 1'b0; wr[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd = '0; wr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",     64'(oBusy),       64'd0);
        chk("reset_grant",    64'(oGrant),      64'd1);
        chk("reset_avm_read", 64'(avmRead),     64'd0);
        chk("reset_avm_wr",   64'(avmWrite),    64'd0);
        chk("reset_tmo_err",  64'(oTimeoutErr), 64'd0);
    endtask

    // Downstream slave: accepts immediately, returns addr+0x10000000 three cycles after accept
    initial begin
        avmWaitReq = 1'b0; avmReadValid = 1'b0; avmReadData = '0;
        forever begin
            @(negedge clk);
            if (avmRead && !avmWaitReq && !slave_mute && !rst) begin
                pend      = 3;
                pend_data = avmAddr + 32'h1000_0000;
            end
            @(posedge clk); #1;
            avmReadValid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    avmReadValid = 1'b1;
                    avmReadData  = pend_data;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a command or completes a port
    initial begin
        cmd_t c;
        cpl_t e;
        bit   have;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ((avmRead || avmWrite) && !avmWaitReq) begin
                    if (exp_cmd.size() == 0) begin
                        flag("unexpected_downstream_cmd", 64'(avmAddr), 64'd0);
                    end else begin
                        c = exp_cmd.pop_front();
                        chk("cmd_write", 64'(avmWrite),     64'(c.wr));
                        chk("cmd_read",  64'(avmRead),      64'(!c.wr));
                        chk("cmd_addr",  64'(avmAddr),      64'(c.addr));
                        chk("cmd_be",    64'(avmBE),        64'(c.be));
                        chk("cmd_wdata", 64'(avmWriteData), 64'(c.wdata));
                    end
                end
                if ((avmRead || avmWrite) && !oBusy)
                    flag("strobe_while_idle", 64'({avmRead, avmWrite}), 64'd0);
                for (int p = 0; p < 2; p++) begin
                    if ((rd[p] || wr[p]) && !waitreq[p]) begin
                        have = 1'b0;
                        if (p == 0 && exp_cpl0.size() != 0) begin e = exp_cpl0.pop_front(); have = 1'b1; end
                        if (p == 1 && exp_cpl1.size() != 0) begin e = exp_cpl1.pop_front(); have = 1'b1; end
                        if (!have) begin
                            flag($sformatf("unexpected_completion_port%0d", p), 64'(waitreq[p]), 64'd1);
                        end else begin
                            chk($sformatf("cpl_rvalid_port%0d", p), 64'(rvalid[p]), 64'(e.is_rd));
                            if (e.is_rd) chk($sformatf("cpl_rdata_port%0d", p), 64'(rdata[p]), 64'(e.data));
                            chk($sformatf("cpl_grant_port%0d", p), 64'(oGrant), 64'(p));
                        end
                    end else if (rvalid[p]) begin
                        flag($sformatf("stray_rvalid_port%0d", p), 64'(rvalid[p]), 64'd0);
                    end
                    if (!(rd[p] || wr[p]) && waitreq[p])
                        flag($sformatf("waitreq_without_req_port%0d", p), 64'(waitreq[p]), 64'd0);
                    if (oGrant != 1'(p) && rdata[p] != '0)
                        flag($sformatf("ungranted_rdata_port%0d", p), 64'(rdata[p]), 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; be[p] = '0; wdata[p] = '0;
        end
        do_reset();

        // Single write from requester 0
        push_cmd(1'b1, 32'hC700_0000, 4'hF, 32'h1234_5678);
        push_cpl(0, 1'b0, '0);
        drive(0, 1'b1, 1'b0, 32'hC700_0000, 4'hF, 32'h1234_5678);
        release_port(0);
        repeat (4) @(posedge clk);

        // Both read continuously: grants 0,1,0,1
        do_reset();
        push_cmd(1'b0, 32'h0000_0100, 4'hF, '0);
        push_cmd(1'b0, 32'h0000_0200, 4'hF, '0);
        push_cmd(1'b0, 32'h0000_0104, 4'hF, '0);
        push_cmd(1'b0, 32'h0000_0204, 4'hF, '0);
        push_cpl(0, 1'b1, 32'h1000_0100);
        push_cpl(0, 1'b1, 32'h1000_0104);
        push_cpl(1, 1'b1, 32'h1000_0200);
        push_cpl(1, 1'b1, 32'h1000_0204);
        fork
            begin
                drive(0, 1'b0, 1'b1, 32'h0000_0100, 4'hF, '0);
                drive(0, 1'b0, 1'b1, 32'h0000_0104, 4'hF, '0);
                release_port(0);
            end
            begin
                drive(1, 1'b0, 1'b1, 32'h0000_0200, 4'hF, '0);
                drive(1, 1'b0, 1'b1, 32'h0000_0204, 4'hF, '0);
                release_port(1);
            end
        join
        repeat (4) @(posedge clk);

        // Requester 0 writes while requester 1 reads, same cycle after reset
        do_reset();
        push_cmd(1'b1, 32'h0000_0400, 4'h3, 32'hCAFE_F00D);
        push_cmd(1'b0, 32'h0000_0300, 4'hF, '0);
        push_cpl(0, 1'b0, '0);
        push_cpl(1, 1'b1, 32'h1000_0300);
        fork
            begin drive(0, 1'b1, 1'b0, 32'h0000_0400, 4'h3, 32'hCAFE_F00D); release_port(0); end
            begin drive(1, 1'b0, 1'b1, 32'h0000_0300, 4'hF, '0);            release_port(1); end
        join
        repeat (4) @(posedge clk);

        // Read and write strobes together count as a write
        push_cmd(1'b1, 32'h0000_0500, 4'hC, 32'h0BAD_F00D);
        push_cpl(0, 1'b0, '0);
        drive(0, 1'b1, 1'b1, 32'h0000_0500, 4'hC, 32'h0BAD_F00D);
        release_port(0);
        repeat (4) @(posedge clk);

        // Downstream stalls a write for two XFER cycles, with a stray readvalid in between
        avmWaitReq = 1'b1;
        push_cmd(1'b1, 32'h0000_0600, 4'hF, 32'h5555_AAAA);
        push_cpl(1, 1'b0, '0);
        fork
            begin drive(1, 1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'h5555_AAAA); release_port(1); end
            begin
                repeat (3) @(posedge clk);
                #2 avmReadValid = 1'b1; avmReadData = 32'hFFFF_FFFF;
                @(posedge clk);
                #2 avmWaitReq = 1'b0;
            end
        join
        repeat (4) @(posedge clk);

        // Reset while waiting in RDATA: no completion, late readvalid ignored
        push_cmd(1'b0, 32'h0000_0700, 4'hF, '0);
        @(posedge clk); #1;
        rd[0] = 1'b1; addr[0] = 32'h0000_0700; be[0] = 4'hF; wdata[0] = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; rd[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_avm_read", 64'(avmRead),   64'd0);
        chk("abort_busy",     64'(oBusy),     64'd0);
        chk("abort_rvalid0",  64'(rvalid[0]), 64'd0);
        chk("abort_grant",    64'(oGrant),    64'd1);
        repeat (6) @(posedge clk);

`ifdef ARB_TIMEOUT_EN
        // Downstream never answers a read: watchdog completes it with the error pattern
        slave_mute = 1'b1;
        push_cmd(1'b0, 32'h0000_0800, 4'hF, '0);
        push_cpl(0, 1'b1, 32'hDEAD_BEEF);
        drive(0, 1'b0, 1'b1, 32'h0000_0800, 4'hF, '0);
        release_port(0);
        slave_mute = 1'b0;
        chk("timeout_err_set", 64'(oTimeoutErr), 64'd1);
        push_cmd(1'b1, 32'h0000_0900, 4'hF, 32'h0000_0001);
        push_cpl(1, 1'b0, '0);
        drive(1, 1'b1, 1'b0, 32'h0000_0900, 4'hF, 32'h0000_0001);
        release_port(1);
        chk("timeout_err_sticky", 64'(oTimeoutErr), 64'd1);
`else
        chk("timeout_err_tied_low", 64'(oTimeoutErr), 64'd0);
`endif

        for (int i = 0; i < BUDGET && (exp_cmd.size() != 0 || exp_cpl0.size() != 0 || exp_cpl1.size() != 0); i++)
            @(negedge clk);
        chk("leftover_cmds",  64'(exp_cmd.size()),  64'd0);
        chk("leftover_cpl0",  64'(exp_cpl0.size()), 64'd0);
        chk("leftover_cpl1",  64'(exp_cpl1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_rr_arbiter.md
Name: avalon_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single Avalon-MM master path feeding the AXI4-Lite master bridge.
- Sits between two Avalon bus masters (e.g. a traffic generator and a CPU-side master) and the bridge's Avalon side.
- Grants one requester at a time and holds the grant for one complete read or write.
- Routes the completion (waitrequest release and read data) back only to the granted requester.

Parameters:
- ADDR_WIDTH, 32, Avalon address width on all ports.
- DATA_WIDTH, 32, Avalon data width; byte-enable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- iClk  in  1  system clock, all logic on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- avalonRead0 / avalonRead1  in  1  read request, requester 0 / 1.
- avalonWrite0 / avalonWrite1  in  1  write request, requester 0 / 1.
- avalonAddr0 / avalonAddr1  in  ADDR_WIDTH  address, requester 0 / 1.
- avalonBE0 / avalonBE1  in  DATA_WIDTH/8  byte enables, requester 0 / 1.
- avalonWriteData0 / avalonWriteData1  in  DATA_WIDTH  write data, requester 0 / 1.
- avalonWaitReq0 / avalonWaitReq1  out  1  waitrequest back to requester 0 / 1.
- avalonReadValid0 / avalonReadValid1  out  1  read data valid, requester 0 / 1.
- avalonReadData0 / avalonReadData1  out  DATA_WIDTH  read data, requester 0 / 1.
- avmRead  out  1  downstream read.
- avmWrite  out  1  downstream write.
- avmAddr  out  ADDR_WIDTH  downstream address.
- avmBE  out  DATA_WIDTH/8  downstream byte enables.
- avmWriteData  out  DATA_WIDTH  downstream write data.
- avmWaitReq  in  1  downstream waitrequest.
- avmReadValid  in  1  downstream read data valid.
- avmReadData  in  DATA_WIDTH  downstream read data.
- oGrant  out  1  index of the current or last granted requester.
- oBusy  out  1  high when state is not IDLE.
- oTimeoutErr  out  1  sticky timeout flag; tied to 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (iRst high at a clock edge):
  - state IDLE; avmRead=avmWrite=0; oBusy=0; oGrant=1, so requester 0 wins the first tie; oTimeoutErr=0.
  - Reset mid-transfer aborts it with no completion to the requester. Downstream strobes are low from the cycle after reset.
- States: IDLE, XFER, RDATA.
- Requests: reqN = avalonReadN | avalonWriteN. If both strobes are high, the access is a write and the read is ignored.
- Arbitration (only in IDLE):
  - One request: grant it.
  - Both requesting: grant the requester that is not oGrant (round-robin).
  - Grant is registered; next state XFER. No grant changes outside IDLE.
- Downstream command path:
  - avmAddr, avmBE and avmWriteData are a combinational mux of the granted requester's inputs.
  - avmRead/avmWrite equal the granted requester's strobes, gated to XFER only.
- XFER:
  - Write: completes in the first cycle with avmWaitReq=0. avalonWaitReqG=0 that cycle; next state IDLE.
  - Read with avmWaitReq=0 and avmReadValid=1 in the same cycle: completes now. avalonReadValidG=1, avalonReadDataG=avmReadData, waitreq low; next state IDLE.
  - Read with avmWaitReq=0 and avmReadValid=0: next state RDATA; avmRead drops.
- RDATA: hold until avmReadValid=1, then complete as above and go to IDLE.
- avalonWaitReqN:
  - 1 whenever reqN is high and the requester is not completing this cycle. Covers a non-granted requester and all IDLE cycles.
  - 0 when reqN is low.
- avalonReadValidN: pulses for exactly one cycle, only on the granted port.
- avalonReadDataN:
  - Granted port mirrors avmReadData.
  - Non-granted port is 0.
- Transfer spacing: one mandatory IDLE cycle between transfers. Minimum write latency is 2 cycles from request to waitreq low (request cycle plus one XFER cycle).
- Stray response: avmReadValid seen in IDLE or during a write is ignored.
- Starvation bound: while both requesters are active, each waits at most one full transfer of the other.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to XFER and increments each cycle in XFER/RDATA.
  - When it reaches TIMEOUT_CYCLES without completion, the arbiter forces completion to the granted requester: waitreq=0, and for reads avalonReadValidG=1 with avalonReadDataG=32'hDEADBEEF.
  - oTimeoutErr sets and stays high until reset; next state IDLE.
  - Completion and timeout in the same cycle: completion wins and no error is set.
- Undefined: no counter; the arbiter waits indefinitely; oTimeoutErr=0.

Test Plan:
- Reset then a single write from requester 0 (addr 0xC7000000, data 0x12345678, BE 0xF), downstream waitreq low on its first cycle -> avmWrite high for exactly 1 cycle with the same addr/data/BE; avalonWaitReq0 low in that cycle; oGrant=0.
- Both requesters read continuously, downstream returns readvalid 3 cycles after accept -> grants alternate 0,1,0,1; each requester sees exactly one avalonReadValid pulse per transfer with the correct data; the other port's waitreq stays high.
- Requester 1 reads while requester 0 writes in the same cycle after reset -> requester 0 is granted first, requester 1 second; both complete.
- iRst asserted in RDATA -> next cycle avmRead=0, oBusy=0, no avalonReadValid pulse; a late avmReadValid is ignored.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, downstream never responds to a read -> after 16 cycles in XFER/RDATA, avalonReadData=0xDEADBEEF with a valid pulse, oTimeoutErr=1 (sticky); the next transfer proceeds normally.
